// File: rtl/pipes.sv
// Shared pipeline types: control bundle, stage-to-stage records and the
// memory-stage handshake state.
package pipes;

    // Access width of a load/store, encoded as log2(bytes).
    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } MemSizeType;

    // Decoded control travelling alongside each instruction.
    typedef struct packed {
        logic       MemRead;
        logic       MemWrite;
        MemSizeType MemSize;
        logic       RegWrite;
        logic [2:0] WBType;
    } control_t;

    // Execute -> memory record.
    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic [31:0] raw_instr;
        control_t    ctl;
        logic [4:0]  dst;
        logic [63:0] alu_out;
        logic [63:0] MemWriteData;
    } execute_data_t;

    // Memory -> writeback record.
    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic [31:0] raw_instr;
        control_t    ctl;
        logic [4:0]  dst;
        logic [63:0] alu_out;
        logic [63:0] MemReadData;
        logic        skip;
    } memory_data_t;

    // Memory-stage sequencing: IDLE accepts work, WAIT owns the data bus.
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

endpackage

// File: rtl/mem_align.sv
// Byte-lane alignment for the data bus: store strobes, store data shift
// into lanes, and load data shift back down to bit 0.
module mem_align
    import pipes::*;
(
    input  logic [2:0]  addr_lo,
    input  MemSizeType  size,
    input  logic        is_store,
    input  logic [63:0] wdata,
    input  logic [63:0] rdata,
    output logic [7:0]  strobe,
    output logic [63:0] wdata_aligned,
    output logic [63:0] rdata_aligned
);

    logic [5:0] shamt;

    assign shamt         = {addr_lo, 3'b000};
    assign wdata_aligned = wdata << shamt;
    assign rdata_aligned = rdata >> shamt;

    // Byte enables for stores; lanes past byte 7 fall off (misaligned), loads use none.
    always_comb begin
        strobe = 8'h00;
        if (is_store) begin
            case (size)
                MSIZE1:  strobe = 8'h01 << addr_lo;
                MSIZE2:  strobe = 8'h03 << addr_lo;
                MSIZE4:  strobe = 8'h0F << addr_lo;
                MSIZE8:  strobe = 8'hFF;
                default: strobe = 8'h00;
            endcase
        end
    end

endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage: passes ALU results straight through in one cycle,
// or holds a load/store on the data bus until the response arrives.
module memory_stage
    import pipes::*;
(
    input  logic          clk,
    input  logic          reset,
    input  execute_data_t in,
    output logic          in_ready,
    output memory_data_t  out,
    input  logic          out_ready,
    input  logic          flush,
    output logic          dreq_valid,
    output logic [63:0]   dreq_addr,
    output MemSizeType    dreq_size,
    output logic [7:0]    dreq_strobe,
    output logic [63:0]   dreq_data,
    input  logic          dresp_data_ok,
    input  logic [63:0]   dresp_data
);

    mem_state_t    state_q, state_d;
    execute_data_t op_q, op_d;
    memory_data_t  out_q, out_d;
    logic          drop_q, drop_d;
    logic [63:0]   rdata_aligned;

    // Build the writeback record; skip marks memory ops to the MMIO half.
    function automatic memory_data_t make_result(input execute_data_t op,
                                                 input logic [63:0] rdata);
        memory_data_t r;
        r.valid       = 1'b1;
        r.pc          = op.pc;
        r.raw_instr   = op.raw_instr;
        r.ctl         = op.ctl;
        r.dst         = op.dst;
        r.alu_out     = op.alu_out;
        r.MemReadData = rdata;
        r.skip        = (op.ctl.MemRead | op.ctl.MemWrite) & ~op.alu_out[31];
        return r;
    endfunction

    // The latched op drives the bus, so the request stays stable throughout WAIT.
    mem_align u_align (
        .addr_lo       (op_q.alu_out[2:0]),
        .size          (op_q.ctl.MemSize),
        .is_store      (op_q.ctl.MemWrite),
        .wdata         (op_q.MemWriteData),
        .rdata         (dresp_data),
        .strobe        (dreq_strobe),
        .wdata_aligned (dreq_data),
        .rdata_aligned (rdata_aligned)
    );

    assign in_ready   = (state_q == IDLE) && (!out_q.valid || out_ready) && !flush;
    assign out        = out_q;
    assign dreq_valid = (state_q == WAIT) && op_q.valid;
    assign dreq_addr  = op_q.alu_out;
    assign dreq_size  = op_q.ctl.MemSize;

    // Next-state logic: accept/drain in IDLE, wait for the bus in WAIT.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        out_d   = out_q;
        drop_d  = drop_q;
        case (state_q)
            IDLE: begin
                if (flush) begin
                    out_d.valid = 1'b0;
                end else if (!out_q.valid || out_ready) begin
                    out_d.valid = 1'b0;
                    if (in.valid) begin
                        if (in.ctl.MemRead || in.ctl.MemWrite) begin
                            op_d    = in;
                            drop_d  = 1'b0;
                            state_d = WAIT;
                        end else begin
                            out_d = make_result(in, 64'h0);
                        end
                    end
                end
            end
            WAIT: begin
                if (out_ready) begin
                    out_d.valid = 1'b0;
                end
                if (flush) begin
                    drop_d = 1'b1;
                end
                if (dresp_data_ok) begin
                    state_d = IDLE;
                    drop_d  = 1'b0;
                    if (!(drop_q || flush)) begin
                        out_d = make_result(op_q, rdata_aligned);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous active-low reset; reset abandons any bus op.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            op_q    <= '0;
            out_q   <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            out_q   <= out_d;
            drop_q  <= drop_d;
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: vector table through a scoreboard,
// plus hand-written back-pressure, flush and reset sequences.
module tb_memory_stage;
    import pipes::*;

    logic          clk = 1'b0;
    logic          reset;
    execute_data_t in_s;
    logic          in_ready;
    memory_data_t  out_s;
    logic          out_ready;
    logic          flush;
    logic          dreq_valid;
    logic [63:0]   dreq_addr;
    MemSizeType    dreq_size;
    logic [7:0]    dreq_strobe;
    logic [63:0]   dreq_data;
    logic          dresp_data_ok;
    logic [63:0]   dresp_data;

    int checks = 0;
    int errors = 0;

    memory_data_t sb_q[$];

    typedef struct {
        string       name;
        logic        rd;
        logic        wr;
        MemSizeType  size;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] resp;
        int          delay;
        logic [7:0]  exp_strobe;
        logic [63:0] exp_ddata;
        logic [63:0] exp_rdata;
        logic        exp_skip;
    } vec_t;

    vec_t vecs[$];

    memory_stage dut (
        .clk           (clk),
        .reset         (reset),
        .in            (in_s),
        .in_ready      (in_ready),
        .out           (out_s),
        .out_ready     (out_ready),
        .flush         (flush),
        .dreq_valid    (dreq_valid),
        .dreq_addr     (dreq_addr),
        .dreq_size     (dreq_size),
        .dreq_strobe   (dreq_strobe),
        .dreq_data     (dreq_data),
        .dresp_data_ok (dresp_data_ok),
        .dresp_data    (dresp_data)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [63:0] actual,
                                input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic add_vec(input string name, input logic rd, input logic wr,
                           input MemSizeType size, input logic [63:0] addr,
                           input logic [63:0] wdata, input logic [63:0] resp,
                           input int delay, input logic [7:0] exp_strobe,
                           input logic [63:0] exp_ddata, input logic [63:0] exp_rdata,
                           input logic exp_skip);
        vec_t v;
        v.name = name; v.rd = rd; v.wr = wr; v.size = size; v.addr = addr;
        v.wdata = wdata; v.resp = resp; v.delay = delay; v.exp_strobe = exp_strobe;
        v.exp_ddata = exp_ddata; v.exp_rdata = exp_rdata; v.exp_skip = exp_skip;
        vecs.push_back(v);
    endtask

    function automatic control_t make_ctl(input logic rd, input logic wr, input MemSizeType size);
        control_t c;
        c          = '0;
        c.MemRead  = rd;
        c.MemWrite = wr;
        c.MemSize  = size;
        c.RegWrite = ~wr;
        c.WBType   = rd ? 3'd1 : 3'd0;
        return c;
    endfunction

    function automatic memory_data_t build_expected(input int idx, input logic rd, input logic wr,
                                                    input MemSizeType size, input logic [63:0] addr,
                                                    input logic [63:0] rdata, input logic skip);
        memory_data_t e;
        e             = '0;
        e.valid       = 1'b1;
        e.pc          = 64'h1000 + 64'(idx * 4);
        e.raw_instr   = 32'h13 + 32'(idx);
        e.ctl         = make_ctl(rd, wr, size);
        e.dst         = 5'(idx);
        e.alu_out     = addr;
        e.MemReadData = rdata;
        e.skip        = skip;
        return e;
    endfunction

    // Called just after a negedge; returns at the negedge following acceptance.
    task automatic apply_stimulus(input int idx, input logic rd, input logic wr,
                                  input MemSizeType size, input logic [63:0] addr,
                                  input logic [63:0] wdata);
        int n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check_output("accept_timeout", 64'(in_ready), 64'd1);
            return;
        end
        in_s              = '0;
        in_s.valid        = 1'b1;
        in_s.pc           = 64'h1000 + 64'(idx * 4);
        in_s.raw_instr    = 32'h13 + 32'(idx);
        in_s.ctl          = make_ctl(rd, wr, size);
        in_s.dst          = 5'(idx);
        in_s.alu_out      = addr;
        in_s.MemWriteData = wdata;
        @(negedge clk);
        in_s.valid = 1'b0;
    endtask

    task automatic expect_out(input string name);
        memory_data_t e;
        int n = 0;
        while (!out_s.valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!out_s.valid) begin
            check_output({name, "_out_timeout"}, 64'(out_s.valid), 64'd1);
            return;
        end
        if (sb_q.size() == 0) begin
            check_output({name, "_sb_empty"}, 64'd0, 64'd1);
            return;
        end
        e = sb_q.pop_front();
        check_output({name, "_valid"}, 64'(out_s.valid), 64'd1);
        check_output({name, "_pc"}, out_s.pc, e.pc);
        check_output({name, "_instr"}, 64'(out_s.raw_instr), 64'(e.raw_instr));
        check_output({name, "_ctl"}, 64'(out_s.ctl), 64'(e.ctl));
        check_output({name, "_dst"}, 64'(out_s.dst), 64'(e.dst));
        check_output({name, "_alu_out"}, out_s.alu_out, e.alu_out);
        check_output({name, "_rdata"}, out_s.MemReadData, e.MemReadData);
        check_output({name, "_skip"}, 64'(out_s.skip), 64'(e.skip));
    endtask

    initial begin
        vec_t v;

        add_vec("add",    0, 0, MSIZE8, 64'h5,                 64'h0,                 64'h0,                 0, 8'h00, 64'h0,                 64'h0,                 0);
        add_vec("sb",     0, 1, MSIZE1, 64'h80000003,          64'hAB,                64'h0,                 1, 8'h08, 64'hAB000000,          64'h0,                 0);
        add_vec("lw",     1, 0, MSIZE4, 64'h80000004,          64'h0,                 64'hDEADBEEF12345678,  3, 8'h00, 64'h0,                 64'hDEADBEEF,          0);
        add_vec("ld",     1, 0, MSIZE8, 64'h10000000,          64'h0,                 64'h1122334455667788,  2, 8'h00, 64'h0,                 64'h1122334455667788,  1);
        add_vec("sh",     0, 1, MSIZE2, 64'h80000006,          64'h123456789ABCBEEF,  64'h0,                 1, 8'hC0, 64'hBEEF000000000000,    64'h0,                 0);
        add_vec("sw",     0, 1, MSIZE4, 64'h80000004,          64'hCAFEBABE,          64'h0,                 2, 8'hF0, 64'hCAFEBABE00000000,    64'h0,                 0);
        add_vec("sd",     0, 1, MSIZE8, 64'h8,                 64'h0123456789ABCDEF,  64'h0,                 1, 8'hFF, 64'h0123456789ABCDEF,    64'h0,                 1);
        add_vec("lb",     1, 0, MSIZE1, 64'h80000007,          64'h0,                 64'hAA00000000000000,  1, 8'h00, 64'h0,                 64'hAA,                0);
        add_vec("sub",    0, 0, MSIZE8, 64'hFFFFFFFF00000000,  64'h0,                 64'h0,                 0, 8'h00, 64'h0,                 64'h0,                 0);
        add_vec("sw_mis", 0, 1, MSIZE4, 64'h80000006,          64'h11223344,          64'h0,                 1, 8'hC0, 64'h3344000000000000,    64'h0,                 0);

        reset         = 1'b0;
        in_s          = '0;
        out_ready     = 1'b1;
        flush         = 1'b0;
        dresp_data_ok = 1'b0;
        dresp_data    = '0;
        repeat (3) @(negedge clk);
        check_output("reset_out_valid", 64'(out_s.valid), 64'd0);
        check_output("reset_out_zero", 64'(out_s.alu_out | out_s.pc), 64'd0);
        check_output("reset_dreq_valid", 64'(dreq_valid), 64'd0);
        reset = 1'b1;
        @(negedge clk);
        check_output("idle_in_ready", 64'(in_ready), 64'd1);

        // Vector table: each op through the scoreboard, bus fields checked every wait cycle.
        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            sb_q.push_back(build_expected(i, v.rd, v.wr, v.size, v.addr, v.exp_rdata, v.exp_skip));
            apply_stimulus(i, v.rd, v.wr, v.size, v.addr, v.wdata);
            if (v.rd || v.wr) begin
                for (int c = 0; c < v.delay; c++) begin
                    check_output({v.name, "_dreq_valid"}, 64'(dreq_valid), 64'd1);
                    check_output({v.name, "_dreq_addr"}, dreq_addr, v.addr);
                    check_output({v.name, "_dreq_size"}, 64'(dreq_size), 64'(v.size));
                    check_output({v.name, "_dreq_strobe"}, 64'(dreq_strobe), 64'(v.exp_strobe));
                    check_output({v.name, "_dreq_data"}, dreq_data, v.exp_ddata);
                    check_output({v.name, "_in_ready_wait"}, 64'(in_ready), 64'd0);
                    if (c == v.delay - 1) begin
                        dresp_data_ok = 1'b1;
                        dresp_data    = v.resp;
                    end
                    @(negedge clk);
                end
                dresp_data_ok = 1'b0;
                dresp_data    = '0;
            end else begin
                check_output({v.name, "_latency1_valid"}, 64'(out_s.valid), 64'd1);
                check_output({v.name, "_no_dreq"}, 64'(dreq_valid), 64'd0);
            end
            expect_out(v.name);
            @(negedge clk);
        end

        // Back-pressure: result held for 4 cycles with in_ready low.
        out_ready = 1'b0;
        sb_q.push_back(build_expected(20, 0, 0, MSIZE8, 64'h77, 64'h0, 0));
        apply_stimulus(20, 0, 0, MSIZE8, 64'h77, 64'h0);
        for (int k = 0; k < 4; k++) begin
            check_output("hold_valid", 64'(out_s.valid), 64'd1);
            check_output("hold_alu_out", out_s.alu_out, 64'h77);
            check_output("hold_in_ready", 64'(in_ready), 64'd0);
            @(negedge clk);
        end
        expect_out("hold");
        out_ready = 1'b1;
        @(negedge clk);
        check_output("hold_release_valid", 64'(out_s.valid), 64'd0);

        // Flush in IDLE drops a stalled result.
        out_ready = 1'b0;
        apply_stimulus(21, 0, 0, MSIZE8, 64'h99, 64'h0);
        check_output("idle_flush_pre_valid", 64'(out_s.valid), 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush     = 1'b0;
        out_ready = 1'b1;
        check_output("idle_flush_valid", 64'(out_s.valid), 64'd0);

        // Flush in WAIT: bus keeps going, completion produces nothing.
        apply_stimulus(22, 1, 0, MSIZE4, 64'h80000000, 64'h0);
        check_output("wflush_dreq_valid", 64'(dreq_valid), 64'd1);
        flush = 1'b1;
        #1;
        check_output("wflush_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        flush = 1'b0;
        check_output("wflush_bus_kept", 64'(dreq_valid), 64'd1);
        check_output("wflush_addr_kept", dreq_addr, 64'h80000000);
        dresp_data_ok = 1'b1;
        dresp_data    = 64'h5555;
        @(negedge clk);
        dresp_data_ok = 1'b0;
        check_output("wflush_out_valid", 64'(out_s.valid), 64'd0);
        check_output("wflush_idle_dreq", 64'(dreq_valid), 64'd0);
        check_output("wflush_idle_ready", 64'(in_ready), 64'd1);
        sb_q.push_back(build_expected(23, 1, 0, MSIZE8, 64'h80000010, 64'hABCD, 0));
        apply_stimulus(23, 1, 0, MSIZE8, 64'h80000010, 64'h0);
        dresp_data_ok = 1'b1;
        dresp_data    = 64'hABCD;
        @(negedge clk);
        dresp_data_ok = 1'b0;
        expect_out("after_flush");
        @(negedge clk);

        // Reset in WAIT abandons the op; a stray response afterwards is ignored.
        apply_stimulus(24, 1, 0, MSIZE8, 64'h80000020, 64'h0);
        check_output("rwait_dreq_valid", 64'(dreq_valid), 64'd1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check_output("rwait_dreq_dropped", 64'(dreq_valid), 64'd0);
        check_output("rwait_out_valid", 64'(out_s.valid), 64'd0);
        dresp_data_ok = 1'b1;
        dresp_data    = 64'h1234;
        @(negedge clk);
        dresp_data_ok = 1'b0;
        check_output("stray_out_valid", 64'(out_s.valid), 64'd0);
        check_output("stray_dreq_valid", 64'(dreq_valid), 64'd0);
        sb_q.push_back(build_expected(25, 0, 0, MSIZE8, 64'h42, 64'h0, 0));
        apply_stimulus(25, 0, 0, MSIZE8, 64'h42, 64'h0);
        expect_out("after_reset");
        @(negedge clk);

        check_output("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
